// File: rtl/shift_pass_sequencer.sv
// Multi-cycle sequencer that drives an external 32-bit logical right barrel shifter in passes of up to MAX_STEP bits.
// Optional build macro SHIFT_SEQ_SATURATE_EN: amounts >= 32 resolve to zero immediately without shifter passes.
module shift_pass_sequencer #(
  parameter int AMT_W    = 8,
  parameter int MAX_STEP = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_data,
  input  logic [AMT_W-1:0] req_amt,
  output logic [31:0]      sh_in,
  output logic [4:0]       sh_load,
  input  logic [31:0]      sh_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [AMT_W-1:0] rsp_passes,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] MAX_STEP_W = AMT_W'(MAX_STEP);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      acc;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] pcnt;
  logic [AMT_W-1:0] step;
  logic [AMT_W-1:0] rem_nxt;

  // Per-pass amount is the remaining shift clamped to what one pass may apply.
  function automatic logic [AMT_W-1:0] clamp_step(input logic [AMT_W-1:0] r);
    return (r > MAX_STEP_W) ? MAX_STEP_W : r;
  endfunction

  assign step       = clamp_step(rem);
  assign rem_nxt    = rem - step;
  assign sh_in      = acc;
  assign rsp_data   = acc;
  assign rsp_passes = pcnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    sh_load   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (req_amt == '0)
            state_nxt = DONE;
`ifdef SHIFT_SEQ_SATURATE_EN
          else if (req_amt >= AMT_W'(32))
            state_nxt = DONE;
`endif
          else
            state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sh_load = 5'(step);
        if (rem_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: load on accept, advance once per pass, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      rem  <= '0;
      pcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc  <= req_data;
            rem  <= req_amt;
            pcnt <= '0;
`ifdef SHIFT_SEQ_SATURATE_EN
            if (req_amt >= AMT_W'(32)) begin
              acc <= '0;
              rem <= '0;
            end
`endif
          end
        end
        SHIFT: begin
          acc  <= sh_out;
          rem  <= rem_nxt;
          pcnt <= pcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_pass_sequencer.sv
// Directed bench for shift_pass_sequencer with a behavioural barrel shifter in the loop.
module tb_shift_pass_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [7:0]  req_amt;
  logic [31:0] sh_in;
  logic [4:0]  sh_load;
  logic [31:0] sh_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_passes;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [4:0] loads [0:15];
  int nload;

  always #5 clk = ~clk;

  assign sh_out = sh_in >> sh_load;

  shift_pass_sequencer #(.AMT_W(8), .MAX_STEP(31)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_amt(req_amt),
    .sh_in(sh_in), .sh_load(sh_load), .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_passes(rsp_passes),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the response, check result, latency and DONE-state outputs.
  task automatic run(input string tag, input logic [31:0] d, input logic [7:0] a,
                     input logic [31:0] ed, input int ep, input bit release_it);
    int cyc;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_data = d; req_amt = a;
    @(negedge clk);
    req_valid = 1'b0; req_data = 32'hDEAD_BEEF; req_amt = 8'hFF;
    cyc = 0; nload = 0;
    while (!rsp_valid && cyc < 400) begin
      if (nload < 16) loads[nload] = sh_load;
      nload++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(ep));
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_passes"}, 32'(rsp_passes), 32'(ep));
    chk({tag, "_doneload"}, 32'(sh_load), 32'd0);
    if (release_it) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_data = '0; req_amt = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_passes", 32'(rsp_passes), 32'd0);
    chk("rst_shin", sh_in, 32'd0);
    chk("rst_shload", 32'(sh_load), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run("amt0", 32'h8000_0000, 8'd0, 32'h8000_0000, 0, 1'b1);
    run("amt20", 32'hFFFF_FFFF, 8'd20, 32'h0000_0FFF, 1, 1'b1);
    chk("amt20_load0", 32'(loads[0]), 32'd20);
`ifdef SHIFT_SEQ_SATURATE_EN
    run("amt40", 32'hF000_0000, 8'd40, 32'h0, 0, 1'b1);
`else
    run("amt40", 32'hF000_0000, 8'd40, 32'h0, 2, 1'b1);
    chk("amt40_load0", 32'(loads[0]), 32'd31);
    chk("amt40_load1", 32'(loads[1]), 32'd9);
`endif
    run("amt31", 32'hF000_0000, 8'd31, 32'h0000_0001, 1, 1'b1);
    chk("amt31_load0", 32'(loads[0]), 32'd31);
`ifdef SHIFT_SEQ_SATURATE_EN
    run("amt255", 32'hFFFF_FFFF, 8'd255, 32'h0, 0, 1'b1);
`else
    run("amt255", 32'hFFFF_FFFF, 8'd255, 32'h0, 9, 1'b1);
    chk("amt255_load0", 32'(loads[0]), 32'd31);
    chk("amt255_load7", 32'(loads[7]), 32'd31);
    chk("amt255_load8", 32'(loads[8]), 32'd7);
`endif

    // Response back-pressure: DONE must hold and ignore new requests.
    run("hold", 32'h1234_5678, 8'd4, 32'h0123_4567, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0]; req_data = 32'h0F0F_0000 + 32'(i); req_amt = 8'd1;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, 32'h0123_4567);
      chk("hold_passes", 32'(rsp_passes), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_release", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Reset during the second SHIFT cycle of a long request.
    req_valid = 1'b1; req_data = 32'hFFFF_FFFF; req_amt = 8'd100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_shift2", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_novalid", 32'(rsp_valid), 32'd0);
    end
    run("after_rst", 32'h0000_0010, 8'd3, 32'h0000_0002, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
